// File: rtl/spi_master_4byte.sv
// ============================================================================
// Module      : spi_master_4byte
// Description : SPI master for the 4-byte frame protocol (32-bit LSB-first
//               frames, init frame then data frames per SS burst).
//               Optional macro SPIM_STATUS_CHECK_EN enables status/overrun
//               reporting on rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_4byte #(
    parameter int         CLK_DIV        = 4,
    parameter int         SS_SETUP       = 4,
    parameter int         FRAME_GAP      = 2,
    parameter logic [7:0] INIT_OPCODE    = 8'h01,
    parameter int         STATUS_ACK_BIT = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic        SPI_SCK,
    output logic        SPI_SS,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [23:0] cmd_data,
    input  logic        cmd_last,
    output logic        rsp_valid,
    input  logic        rsp_ack,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SS_SETUP   = 3'd1,
        ST_INIT_FRAME = 3'd2,
        ST_GAP        = 3'd3,
        ST_DATA_FRAME = 3'd4,
        ST_SS_HOLD    = 3'd5
    } state_t;

    localparam int          C_GAP_CLKS     = (FRAME_GAP * CLK_DIV > 0) ? FRAME_GAP * CLK_DIV : 1;
    localparam logic [7:0]  c_div_last     = 8'(CLK_DIV - 1);
    localparam logic [15:0] c_setup        = 16'(SS_SETUP);
    localparam logic [15:0] c_setup_last   = 16'(SS_SETUP - 1);
    localparam logic [15:0] c_gap_last     = 16'(C_GAP_CLKS - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sck_q, sck_d;
    logic        ss_q, ss_d;
    logic        mosi_q, mosi_d;
    logic [31:0] tx_q, tx_d;
    logic [31:0] rx_q, rx_d;
    logic [7:0]  op_q, op_d;
    logic [23:0] data_q, data_d;
    logic        last_q, last_d;
    logic        have_q, have_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
`ifdef SPIM_STATUS_CHECK_EN
    logic        rsp_err_q, rsp_err_d;
    logic        ovr_q, ovr_d;
`endif

    logic        w_hs;
    logic [31:0] w_rx_next;

    assign w_hs      = cmd_valid & cmd_ready_q;
    assign w_rx_next = {SPI_MISO, rx_q[31:1]};

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        op_d        = op_q;
        data_d      = data_q;
        last_d      = last_q;
        have_d      = have_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef SPIM_STATUS_CHECK_EN
        rsp_err_d   = rsp_err_q;
        ovr_d       = ovr_q;
`endif

        if (w_hs) begin
            op_d   = cmd_opcode;
            data_d = cmd_data;
            last_d = cmd_last;
            have_d = 1'b1;
        end

        if (rsp_valid_q && rsp_ack) begin
            rsp_valid_d = 1'b0;
`ifdef SPIM_STATUS_CHECK_EN
            ovr_d       = 1'b0;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                // cnt_q counts SS-high time so back-to-back bursts keep SS high long enough
                if (w_hs) begin
                    state_d = ST_SS_SETUP;
                    ss_d    = 1'b0;
                    cnt_d   = 16'd0;
                end else if (cnt_q < c_setup) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SS_SETUP: begin
                if (cnt_q >= c_setup_last) begin
                    state_d = ST_INIT_FRAME;
                    tx_d    = {24'h0, INIT_OPCODE};
                    mosi_d  = INIT_OPCODE[0];
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_INIT_FRAME, ST_DATA_FRAME: begin
                if (div_q == c_div_last) begin
                    div_d = 8'd0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        rx_d  = w_rx_next;
                        if (bit_q == 5'd31) begin
                            bit_d  = 5'd0;
                            mosi_d = 1'b0;
                            cnt_d  = 16'd0;
                            if (state_q == ST_INIT_FRAME) begin
                                state_d = ST_GAP;
                            end else begin
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = w_rx_next;
`ifdef SPIM_STATUS_CHECK_EN
                                ovr_d       = rsp_valid_q & ~rsp_ack;
                                rsp_err_d   = ~w_rx_next[STATUS_ACK_BIT] | ovr_d;
`endif
                                state_d     = last_q ? ST_SS_HOLD : ST_GAP;
                            end
                        end else begin
                            bit_d  = bit_q + 5'd1;
                            tx_d   = {1'b0, tx_q[31:1]};
                            mosi_d = tx_q[1];
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_GAP: begin
                // SCK idles low here for as long as no follow-up command is pending
                if (cnt_q < c_gap_last) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (have_q) begin
                    state_d = ST_DATA_FRAME;
                    tx_d    = {data_q, op_q};
                    mosi_d  = op_q[0];
                    have_d  = 1'b0;
                    div_d   = 8'd0;
                    bit_d   = 5'd0;
                end
            end
            ST_SS_HOLD: begin
                if (cnt_q >= c_setup_last) begin
                    state_d = ST_IDLE;
                    ss_d    = 1'b1;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = ((state_d == ST_IDLE) && (cnt_d >= c_setup)) ||
                      ((state_d == ST_GAP) && !have_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= 8'd0;
            bit_q       <= 5'd0;
            cnt_q       <= c_setup;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            tx_q        <= 32'd0;
            rx_q        <= 32'd0;
            op_q        <= 8'd0;
            data_q      <= 24'd0;
            last_q      <= 1'b0;
            have_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
`ifdef SPIM_STATUS_CHECK_EN
            rsp_err_q   <= 1'b0;
            ovr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            op_q        <= op_d;
            data_q      <= data_d;
            last_q      <= last_d;
            have_q      <= have_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef SPIM_STATUS_CHECK_EN
            rsp_err_q   <= rsp_err_d;
            ovr_q       <= ovr_d;
`endif
        end
    end

    assign SPI_SCK   = sck_q;
    assign SPI_SS    = ss_q;
    assign SPI_MOSI  = mosi_q;
    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef SPIM_STATUS_CHECK_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/spi_master_4byte.md
Name: spi_master_4byte

Overview:
- FPGA-side SPI master that speaks the team's 4-byte frame protocol: 32-bit frames, LSB first, byte0 = opcode/status, bytes 1-3 = 24-bit payload.
- Each transaction: assert SS, send init frame (opcode 0x01), send one or more data frames, release SS.
- Used to drive the slave-side receiver in loopback and to talk to peer FPGA/DDS boards.
- User side is a valid/ready command port and a valid/ack response port.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal range 4..255 (slave oversamples SCK through 2 FFs).
- SS_SETUP, 4, clk cycles from SS low to first SCK rising edge, and from last SCK falling edge to SS high.
- FRAME_GAP, 2, SCK half-periods of idle-low SCK between consecutive frames.
- INIT_OPCODE, 8'h01, opcode byte of the init frame.
- STATUS_ACK_BIT, 5, index of the slave "frame accepted" bit in the returned status byte.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- SPI_SCK  output  1  SPI clock, idle low
- SPI_SS  output  1  slave select, active low, idle high
- SPI_MOSI  output  1  master data out
- SPI_MISO  input  1  slave data in
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid & ready
- cmd_opcode  input  8  byte0 of data frame
- cmd_data  input  24  payload, bits 31:8 of frame
- cmd_last  input  1  release SS after this frame
- rsp_valid  output  1  response frame available
- rsp_ack  input  1  consumer acknowledge
- rsp_data  output  32  full MISO frame of last data frame
- rsp_err  output  1  slave status ack missing (see Optional Feature)
- busy  output  1  high whenever SS is low or a frame is in progress

Behaviour:
- Reset (reset==0 at clk edge): SPI_SS=1, SPI_SCK=0, SPI_MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, state=IDLE. Reset mid-frame aborts immediately; no partial response is emitted.
- States: IDLE -> SS_SETUP -> INIT_FRAME -> GAP -> DATA_FRAME -> (GAP -> DATA_FRAME)* -> SS_HOLD -> IDLE.
- IDLE: cmd_ready=1. Handshake latches opcode/data/last, cmd_ready drops next cycle, SS goes low, state goes to SS_SETUP.
- INIT_FRAME shifts {24'h0, INIT_OPCODE}. MISO from the init frame is discarded.
- DATA_FRAME shifts {cmd_data, cmd_opcode}.
- Bit timing: MOSI is valid before each SCK rising edge. Bit 0 is driven when entering the frame; bit n+1 is driven on the clk where SCK falls after bit n.
- Each SCK phase lasts exactly CLK_DIV clks. MISO is sampled on the last clk of each high phase. The 32 samples are shifted LSB first into a 32-bit register.
- Frame = exactly 32 SCK pulses; 5-bit bit counter wraps 31->0 at frame end.
- After DATA_FRAME: load rsp_data and set rsp_valid. If cmd_last was set, go to SS_HOLD. Otherwise go to GAP and raise cmd_ready for one-or-more clks; a handshake there latches the next frame.
- If no command arrives by the end of GAP, hold SCK low and keep SS low until a command arrives (SS is never released unless last=1).
- SS_HOLD: wait SS_SETUP clks, SS high, then IDLE. SS high time is at least SS_SETUP clks before the next SS_SETUP.
- Response: rsp_valid stays high until the clk after rsp_ack==1.
- If a new data frame completes while rsp_valid=1 and no ack has arrived, the old response is overwritten with the new one, rsp_valid stays 1, and an internal overrun flag is set. Overrun is cleared on ack.
- Simultaneous ack and new frame completion: new data is loaded and rsp_valid remains 1.
- busy = (state != IDLE).

Optional Feature:
- SPIM_STATUS_CHECK_EN:
  - Defined: rsp_err is loaded with ~MISO_frame[STATUS_ACK_BIT] together with rsp_data. rsp_err is also set if the overrun flag is set at load.
  - Not defined: rsp_err is tied 0 and there is no overrun logic.

Test Plan:
- Single frame, CLK_DIV=4, cmd opcode=0x02, data=0xCAFE77, last=1 -> MOSI stream: 0x00000001 then 0xCAFE7702, LSB first; 64 SCK pulses, each phase 4 clks. SS low for whole burst; rsp_valid once.
- MISO model returns 0x12345620 on the data frame -> rsp_data=0x12345620. With SPIM_STATUS_CHECK_EN, rsp_err=0 (bit5=1). With MISO=0x00000000, rsp_err=1.
- Burst of 3 commands, last only on third -> one init frame, 3 data frames, FRAME_GAP gaps, SS never high between frames, 3 rsp_valid pulses with ack.
- No ack across 2 frames -> rsp_data holds the second frame. With the macro defined, rsp_err=1; after ack, rsp_valid=0 on next clk.
- reset=0 asserted at bit 17 of a data frame -> next clk SS=1, SCK=0, rsp_valid=0. After release, a new command runs a full init+data sequence.
- Loopback against the receiver block, opcode 0x05, data 0xA5A5A5 -> receiver rd_data=0xA5A5A505.
